// File: rtl/tx_framer_if.sv
// Character-input handshake between the CPU side and tx_framer.
// The master drives characters; the slave (the framer) answers with in_ready.
interface tx_framer_if;
   logic [6:0] in_data;
   logic       in_last;
   logic       in_valid;
   logic       in_ready;

   modport master (
      output in_data,
      output in_last,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_last,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/tx_framer.sv
// tx_framer: buffers CPU characters in a FIFO and emits each message on the
// 7-bit line tx as 00 (start marker), payload characters, then 7F (idle).
// Optional feature macro TXF_SUBST_EN: when defined, illegal characters
// (00 or 7F) are stored as SUBST_CHAR; otherwise they are stored as 00 and
// show up on the line as a fill cycle.
module tx_framer #(
   parameter int         DEPTH      = 8,
   parameter logic [6:0] SUBST_CHAR = 7'h3F
) (
   input  logic          clk,
   input  logic          reset,
   tx_framer_if.slave    in_if,
   input  logic          err_clr,
   output logic [6:0]    tx,
   output logic          busy,
   output logic          err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   localparam logic [6:0] CHAR_START = 7'h00;
   localparam logic [6:0] CHAR_IDLE  = 7'h7F;

`ifdef TXF_SUBST_EN
   localparam logic [6:0] ILLEGAL_STORE = SUBST_CHAR;
`else
   // Substitute character is masked off so illegal characters become fill cycles.
   localparam logic [6:0] ILLEGAL_STORE = SUBST_CHAR & 7'h00;
`endif

   // S_LAST is the frame cycle carrying the final character; the line is
   // still busy there and returns to idle unconditionally on the next edge,
   // which guarantees the 7F gap between back-to-back frames.
   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_LAST
   } state_t;

   state_t          state_q, state_d;
   logic [6:0]      tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            err_q, err_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      mem_q [DEPTH];

   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            illegal;
   logic [7:0]      wr_entry;
   logic [7:0]      rd_entry;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_if.in_ready = !reset && !full;
   assign push     = in_if.in_valid && in_if.in_ready;
   assign illegal  = (in_if.in_data == CHAR_START) || (in_if.in_data == CHAR_IDLE);
   assign rd_entry = mem_q[rd_ptr_q];

   assign tx   = tx_q;
   assign busy = busy_q;
   assign err  = err_q;

   // Build the FIFO entry {last, char}, replacing illegal characters.
   always_comb begin
      wr_entry = {in_if.in_last, in_if.in_data};
      if (illegal) begin
         wr_entry = {in_if.in_last, ILLEGAL_STORE};
      end
   end

   // Frame sequencing: choose the next state and the line value it shows.
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = S_START;
               tx_d    = CHAR_START;
               busy_d  = 1'b1;
            end else begin
               tx_d    = CHAR_IDLE;
               busy_d  = 1'b0;
            end
         end
         S_START, S_DATA: begin
            busy_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               tx_d    = rd_entry[6:0];
               state_d = rd_entry[7] ? S_LAST : S_DATA;
            end else begin
               tx_d    = CHAR_START;
               state_d = S_DATA;
            end
         end
         S_LAST: begin
            state_d = S_IDLE;
            tx_d    = CHAR_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = CHAR_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // FIFO pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Sticky error flag; a new illegal accept wins over a clear.
   always_comb begin
      err_d = err_q;
      if (push && illegal) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   // Control registers; reset flushes the FIFO and forces the line idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         tx_q     <= CHAR_IDLE;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage; contents need no reset because occupancy gates reads.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

endmodule

// File: tb/tb_tx_framer.sv
// Testbench for tx_framer: directed frame sequences plus randomized traffic
// decoded by a receiver model that rebuilds the printed messages.
module tb_tx_framer;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       err_clr;
   logic [6:0] tx;
   logic       busy;
   logic       err;

   tx_framer_if bus ();

   tx_framer #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .in_if   (bus),
      .err_clr (err_clr),
      .tx      (tx),
      .busy    (busy),
      .err     (err)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [6:0] cap_tx[$];
   logic       cap_busy[$];

   // Receiver/model state for the randomized phases.
   int         count_m;
   bit         in_frame;
   bit         saw_full;
   int         cur_len;
   logic [6:0] exp_chars[$];
   int         exp_lens[$];
   logic [6:0] printed[$];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [6:0] data, input logic last);
      bus.in_valid = valid;
      bus.in_data  = data;
      bus.in_last  = last;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cap_tx.push_back(tx);
      cap_busy.push_back(busy);
   endtask

   task automatic clear_capture();
      cap_tx.delete();
      cap_busy.delete();
   endtask

   task automatic idle_wait();
      applyStimulus(1'b0, 7'h00, 1'b0);
      repeat (4 * DEPTH + 8) step();
      clear_capture();
   endtask

   task automatic check_seq(input string tag, input logic [6:0] expv[$]);
      checkOutput({tag, "_len"}, cap_tx.size(), expv.size());
      for (int i = 0; i < expv.size() && i < cap_tx.size(); i++) begin
         checkOutput($sformatf("%s[%0d]", tag, i), cap_tx[i], expv[i]);
      end
   endtask

   function automatic int busy_cycles();
      int n = 0;
      foreach (cap_busy[i]) if (cap_busy[i]) n++;
      return n;
   endfunction

   task automatic frame_end();
      int n;
      logic [6:0] e;
      if (exp_lens.size() == 0) begin
         checkOutput("unexpected_frame", 1, 0);
      end else begin
         n = exp_lens.pop_front();
         checkOutput("frame_len", printed.size(), n);
         for (int i = 0; i < n; i++) begin
            e = (exp_chars.size() > 0) ? exp_chars.pop_front() : 7'h7F;
            if (i < printed.size()) checkOutput("frame_char", printed[i], e);
         end
      end
   endtask

   // One clock of randomized traffic, followed by the receiver-side checks.
   task automatic model_cycle(input logic v, input logic [6:0] d, input logic l);
      bit acc;
      applyStimulus(v, d, l);
      acc = v && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
         count_m++;
         exp_chars.push_back(d);
         cur_len++;
         if (l) begin
            exp_lens.push_back(cur_len);
            cur_len = 0;
         end
      end
      if (tx != 7'h00 && tx != 7'h7F) count_m--;
      checkOutput("in_ready", bus.in_ready, count_m != DEPTH);
      if (!bus.in_ready) saw_full = 1'b1;
      checkOutput("busy_vs_line", busy, tx != 7'h7F);
      if (!in_frame) begin
         if (tx != 7'h7F) begin
            checkOutput("frame_start", tx, 7'h00);
            in_frame = 1'b1;
            printed.delete();
         end
      end else if (tx == 7'h7F) begin
         in_frame = 1'b0;
         frame_end();
      end else if (tx != 7'h00) begin
         printed.push_back(tx);
      end
   endtask

   task automatic run_phase(input int cycles, input int p_valid, input int p_last);
      int guard;
      count_m  = 0;
      in_frame = 1'b0;
      saw_full = 1'b0;
      cur_len  = 0;
      exp_chars.delete();
      exp_lens.delete();
      printed.delete();
      for (int c = 0; c < cycles; c++) begin
         if ($urandom_range(99, 0) < p_valid)
            model_cycle(1'b1, 7'($urandom_range(126, 1)), $urandom_range(99, 0) < p_last);
         else
            model_cycle(1'b0, 7'h00, 1'b0);
      end
      guard = 0;
      while (cur_len > 0 && guard < 100) begin
         model_cycle(1'b1, 7'h2E, 1'b1);
         guard++;
      end
      guard = 0;
      while ((exp_lens.size() > 0 || in_frame) && guard < 500) begin
         model_cycle(1'b0, 7'h00, 1'b0);
         guard++;
      end
      checkOutput("drain_done", exp_lens.size() + int'(in_frame), 0);
      checkOutput("fifo_empty", count_m, 0);
      applyStimulus(1'b0, 7'h00, 1'b0);
   endtask

   // Safety net so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence of directed and randomized scenarios.
   initial begin
      logic [6:0] expv[$];
      logic [6:0] subst_exp;
      bit         post_ok;

      reset   = 1'b1;
      err_clr = 1'b0;
      applyStimulus(1'b0, 7'h00, 1'b0);
      #2;
      checkOutput("reset_tx", tx, 7'h7F);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_err", err, 1'b0);
      checkOutput("reset_in_ready", bus.in_ready, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("post_reset_in_ready", bus.in_ready, 1'b1);
      idle_wait();

      // "Hi" into an idle block.
      applyStimulus(1'b1, 7'h48, 1'b0); step();
      applyStimulus(1'b1, 7'h69, 1'b1); step();
      applyStimulus(1'b0, 7'h00, 1'b0);
      repeat (3) step();
      expv = '{7'h7F, 7'h00, 7'h48, 7'h69, 7'h7F};
      check_seq("hi_seq", expv);
      checkOutput("hi_busy_cycles", busy_cycles(), 3);
      idle_wait();

      // 'A', a pause, then 'B' closing the message.
      applyStimulus(1'b1, 7'h41, 1'b0); step();
      applyStimulus(1'b0, 7'h00, 1'b0);
      repeat (5) step();
      applyStimulus(1'b1, 7'h42, 1'b1); step();
      applyStimulus(1'b0, 7'h00, 1'b0);
      repeat (2) step();
      expv = '{7'h7F, 7'h00, 7'h41, 7'h00, 7'h00, 7'h00, 7'h00, 7'h42, 7'h7F};
      check_seq("gap_seq", expv);
      idle_wait();

      // Two single-character messages back-to-back.
      applyStimulus(1'b1, 7'h78, 1'b1); step();
      applyStimulus(1'b1, 7'h79, 1'b1); step();
      applyStimulus(1'b0, 7'h00, 1'b0);
      repeat (5) step();
      expv = '{7'h7F, 7'h00, 7'h78, 7'h7F, 7'h00, 7'h79, 7'h7F};
      check_seq("two_msg_seq", expv);
      idle_wait();

      // Illegal 7F closing a frame, sticky error and clear behaviour.
`ifdef TXF_SUBST_EN
      subst_exp = 7'h3F;
`else
      subst_exp = 7'h00;
`endif
      applyStimulus(1'b1, 7'h61, 1'b0); step();
      checkOutput("err_before_illegal", err, 1'b0);
      applyStimulus(1'b1, 7'h7F, 1'b1); step();
      checkOutput("err_set", err, 1'b1);
      applyStimulus(1'b0, 7'h00, 1'b0);
      repeat (3) step();
      expv = '{7'h7F, 7'h00, 7'h61, subst_exp, 7'h7F};
      check_seq("illegal_seq", expv);
      checkOutput("err_sticky", err, 1'b1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      checkOutput("err_cleared", err, 1'b0);
      err_clr = 1'b1;
      applyStimulus(1'b1, 7'h00, 1'b1); step();
      err_clr = 1'b0;
      applyStimulus(1'b0, 7'h00, 1'b0);
      checkOutput("err_set_wins", err, 1'b1);
      repeat (4) step();
      checkOutput("stored_00_closes_tx", tx, 7'h7F);
      checkOutput("stored_00_closes_busy", busy, 1'b0);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      idle_wait();

      // Reset in the middle of a 4-character frame.
      applyStimulus(1'b1, 7'h61, 1'b0); step();
      applyStimulus(1'b1, 7'h62, 1'b0); step();
      applyStimulus(1'b1, 7'h63, 1'b0); step();
      applyStimulus(1'b1, 7'h64, 1'b1); step();
      applyStimulus(1'b0, 7'h00, 1'b0);
      checkOutput("pre_reset_char", tx, 7'h62);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midreset_tx", tx, 7'h7F);
      checkOutput("midreset_busy", busy, 1'b0);
      checkOutput("midreset_in_ready", bus.in_ready, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("release_in_ready", bus.in_ready, 1'b1);
      clear_capture();
      repeat (8) step();
      post_ok = 1'b1;
      foreach (cap_tx[i]) if (cap_tx[i] != 7'h7F || cap_busy[i]) post_ok = 1'b0;
      checkOutput("no_residual", post_ok, 1'b1);
      clear_capture();

      // Randomized traffic with legal characters.
      run_phase(400, 60, 25);
      $display("[TB] random phase done, checks so far %0d", checks);

      // Single-character messages every cycle until the FIFO fills.
      run_phase(40, 100, 100);
      checkOutput("saw_full", saw_full, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
